// File: rtl/regread_pkg.sv
// Shared constants for the register-file read-port arbiter.
// State encoding and register index sizing.
package regread_pkg;

  localparam int REG_IDX_W  = 5;
  localparam int NUM_REGS   = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Searches req upward from ptr, wrapping at N-1.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);

  // First asserted request at or after ptr wins
  always_comb begin
    int c;
    logic [W-1:0] ci;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    c      = 0;
    ci     = '0;
    for (int off = 0; off < N; off++) begin
      c = int'(ptr) + off;
      if (c >= N) c = c - N;
      ci = W'(c);
      if (!any && req[ci]) begin
        any        = 1'b1;
        onehot[ci] = 1'b1;
        idx        = ci;
      end
    end
  end

endmodule

// File: rtl/regread_rr_arbiter.sv
// Round-robin arbiter sharing the register-file read mux.
// Optional macro REGREAD_ZERO_EN forces x0 reads to return zero.
module regread_rr_arbiter
  import regread_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [REG_IDX_W*NUM_REQ-1:0] req_addr,
  input  logic                         stall,
  output logic [NUM_REQ-1:0]           grant,
  output logic [REG_IDX_W-1:0]         mux_select,
  input  logic [DATA_W-1:0]            mux_data,
  output logic                         resp_valid,
  output logic [ID_W-1:0]              resp_id,
  output logic [DATA_W-1:0]            resp_data,
  output logic                         busy
);

  state_t               state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      s1_id;
  logic                 s1_zero;

  logic [NUM_REQ-1:0]   win_oh;
  logic [ID_W-1:0]      win_idx;
  logic                 win_any;
  logic [ID_W-1:0]      nxt_ptr;
  logic [REG_IDX_W-1:0] win_addr;

  logic [REG_IDX_W-1:0] addr_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign addr_arr[i] = req_addr[i*REG_IDX_W +: REG_IDX_W];
  end

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (win_oh),
    .idx    (win_idx),
    .any    (win_any)
  );

  assign win_addr = addr_arr[win_idx];
  assign nxt_ptr  = (win_idx == ID_W'(NUM_REQ - 1))
                  ? '0 : win_idx + 1'b1;
  assign busy     = (state == ST_ISSUE);

  // Stage 1: arbitrate, register grant and mux select
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      mux_select <= '0;
      rr_ptr     <= '0;
      s1_id      <= '0;
      s1_zero    <= 1'b0;
    end else if (!stall && win_any) begin
      state      <= ST_ISSUE;
      grant      <= win_oh;
      mux_select <= win_addr;
      rr_ptr     <= nxt_ptr;
      s1_id      <= win_idx;
      s1_zero    <= (win_addr == '0);
    end else begin
      state      <= ST_IDLE;
      grant      <= '0;
    end
  end

  // Stage 2: capture mux output for the stage-1 winner
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid <= busy;
      if (busy) begin
        resp_id <= s1_id;
`ifdef REGREAD_ZERO_EN
        resp_data <= s1_zero ? '0 : mux_data;
`else
        resp_data <= mux_data;
`endif
      end
    end
  end

`ifndef REGREAD_ZERO_EN
  logic unused_zero;
  assign unused_zero = s1_zero;
`endif

endmodule

// File: tb/tb_regread_rr_arbiter.sv
// Testbench for regread_rr_arbiter.
// Directed steps plus random traffic against a queue-free reference model.
module tb_regread_rr_arbiter;

  localparam int N = 4;

`ifdef REGREAD_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [19:0] req_addr;
  logic        stall;
  logic [3:0]  grant;
  logic [4:0]  mux_select;
  logic [31:0] mux_data;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [31:0] resp_data;
  logic        busy;

  logic [31:0] rf [32];

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_ptr;
  bit          m_s1v;
  int          m_s1id;
  bit          m_s1zero;
  logic [4:0]  m_sel;

  always #5 clock = ~clock;

  always_comb mux_data = rf[mux_select];

  regread_rr_arbiter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .req_addr   (req_addr),
    .stall      (stall),
    .grant      (grant),
    .mux_select (mux_select),
    .mux_data   (mux_data),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_s1v    = 1'b0;
    m_s1id   = 0;
    m_s1zero = 1'b0;
    m_sel    = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_sel"},   32'(mux_select), 32'd0);
    check({tag, "_rv"},    32'(resp_valid), 32'd0);
    check({tag, "_rid"},   32'(resp_id), 32'd0);
    check({tag, "_rdata"}, resp_data, 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  // Advance one clock; predict and compare every output
  task automatic step(input string tag);
    bit          e_rv;
    int          e_rid;
    logic [31:0] e_rdata;
    logic [3:0]  e_grant;
    int          w;
    int          i;
    logic [4:0]  a;
    e_rv    = m_s1v;
    e_rid   = m_s1id;
    e_rdata = (ZERO_EN && m_s1zero) ? 32'd0 : rf[m_sel];
    w = -1;
    if (!stall) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (w < 0 && req[i]) w = i;
      end
    end
    if (w >= 0) begin
      a        = req_addr[w*5 +: 5];
      e_grant  = 4'(1 << w);
      m_sel    = a;
      m_s1v    = 1'b1;
      m_s1id   = w;
      m_s1zero = (a == 5'd0);
      m_ptr    = (w + 1) % N;
    end else begin
      e_grant = 4'd0;
      m_s1v   = 1'b0;
    end
    @(posedge clock);
    #1;
    check({tag, "_grant"}, 32'(grant), 32'(e_grant));
    check({tag, "_busy"},  32'(busy), 32'(m_s1v));
    check({tag, "_sel"},   32'(mux_select), 32'(m_sel));
    check({tag, "_rv"},    32'(resp_valid), 32'(e_rv));
    if (e_rv) begin
      check({tag, "_rid"},   32'(resp_id), 32'(e_rid));
      check({tag, "_rdata"}, resp_data, e_rdata);
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = $urandom;
    reset_n  = 1'b0;
    req      = 4'b1111;
    req_addr = {5'd4, 5'd3, 5'd2, 5'd1};
    stall    = 1'b0;
    model_reset();

    // reset held with all requests pending
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("rst");
    @(negedge clock);
    reset_n = 1'b1;
    step("rst_first");
    step("rst_second");

    // single read by requester 2
    req = 4'b0000;
    step("idle0");
    rf[17]   = 32'hDEAD_0011;
    req      = 4'b0100;
    req_addr = {5'd9, 5'd17, 5'd8, 5'd7};
    step("single_g");
    req = 4'b0000;
    step("single_r");

    // fairness: all requesting for 8 cycles
    req = 4'b1111;
    for (int c = 0; c < 8; c++) step("fair");
    req = 4'b0000;
    step("fair_drain");

    // wrap: move pointer to 3, then 4'b1001
    req = 4'b0100;
    step("wrap_pre");
    req = 4'b1001;
    step("wrap_3");
    step("wrap_0");
    req = 4'b0000;
    step("wrap_idle0");
    step("wrap_idle1");
    req = 4'b0011;
    step("wrap_ptr1");
    req = 4'b0000;
    step("wrap_drain");

    // stall: a grant issued just before the stall still responds
    req = 4'b1000;
    step("stall_pre");
    req   = 4'b0010;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) step("stall_on");
    stall = 1'b0;
    step("stall_off");
    req = 4'b0000;
    step("stall_drain");

    // address 0 read with all-ones mux data
    rf[0]    = 32'hFFFF_FFFF;
    req      = 4'b0001;
    req_addr = {5'd3, 5'd2, 5'd1, 5'd0};
    step("zero_g");
    req = 4'b0000;
    step("zero_r");
    check("zero_data", resp_data,
          ZERO_EN ? 32'd0 : 32'hFFFF_FFFF);

    // reset in the middle of traffic
    req = 4'b1111;
    step("mid_a");
    step("mid_b");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("mid_rst");
    req = 4'b0000;
    @(negedge clock);
    reset_n = 1'b1;
    step("mid_after0");
    step("mid_after1");

    // randomized traffic
    for (int c = 0; c < 300; c++) begin
      req      = 4'($urandom);
      req_addr = 20'($urandom);
      stall    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0)
        rf[$urandom_range(0, 31)] = $urandom;
      step("rand");
    end
    req   = 4'b0000;
    stall = 1'b0;
    step("end0");
    step("end1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regread_rr_arbiter.md
Name: regread_rr_arbiter

Overview:
- Shares the single 32:1 register-file read mux between NUM_REQ requesters (decode, writeback bypass check, debug port, multdiv operand fetch).
- Round-robin arbitration, registered select into the mux, and a registered response carrying the mux output back to the winner.
- Sits between the requesting stages and the read-port mux tree; the mux itself stays purely combinational.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester index, must equal clog2(NUM_REQ)
- DATA_W, 32, register data width

Ports:
- clock  input  1  single system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  per-requester read request, level
- req_addr  input  5*NUM_REQ  register index per requester, slice i = [5i+4:5i]
- stall  input  1  inhibit new grants; an in-flight read still completes
- grant  output  NUM_REQ  one-hot, one-cycle pulse to the winner
- mux_select  output  5  drives the read mux select, registered
- mux_data  input  DATA_W  combinational output of the read mux
- resp_valid  output  1  one-cycle pulse, read data available
- resp_id  output  ID_W  index of the requester owning resp_data
- resp_data  output  DATA_W  registered read data
- busy  output  1  high while a granted read is in flight

Behaviour:
- Reset (async assert, sync-released deassert): grant=0, mux_select=0, resp_valid=0, resp_id=0, resp_data=0, busy=0, rr_ptr=0.
- Two-stage pipeline, one grant per cycle maximum:
  - Cycle T: arbitration.
  - T+1: grant, mux_select and busy are driven.
  - T+2: resp_valid, resp_id and resp_data are driven.
  - Latency: 2 cycles from req sampled to resp_valid.
- Arbitration at edge T, when stall=0:
  - Winner = first asserted req[i] searching from index rr_ptr upward, wrapping at NUM_REQ-1 back to 0.
  - On a win: grant[winner]=1 and mux_select=req_addr slice of the winner for exactly one cycle. The winner index is stored in stage-1 id, and rr_ptr = (winner+1) mod NUM_REQ.
  - When no req is asserted: grant=0, mux_select holds its previous value, rr_ptr is unchanged.
- Stall:
  - stall=1 at edge T means no grant at T+1 and rr_ptr is unchanged.
  - A stage-1 read already granted still produces its response at T+1→T+2.
- Handshake:
  - A requester holds req and req_addr stable until it sees grant.
  - It drops req in the cycle after grant unless it wants another read.
  - req still high one cycle after grant is a new request and competes normally; the pointer has already moved past it.
- Back-to-back reads: a new grant may issue every cycle. Stage 2 captures mux_data at the edge following each grant, tagged with the stage-1 id.
- States:
  - IDLE: busy=0, no stage-1 entry.
  - ISSUE: stage-1 valid; busy=1 for exactly the grant cycle.
  - Transition IDLE→ISSUE on a win; ISSUE→ISSUE on a back-to-back win; ISSUE→IDLE otherwise.
- Simultaneous events: every req asserted with rr_ptr=k means grant order k, k+1, …, wrapping. No requester waits more than NUM_REQ-1 grants.
- Reset mid-operation: in-flight read discarded; no resp_valid after reset release until a fresh grant.
- req_addr of requesters that are not granted is ignored; values are unconstrained.

Optional Feature:
- Macro REGREAD_ZERO_EN.
- Defined: when the granted address is 0, stage 2 returns resp_data=0 regardless of mux_data; resp_valid and resp_id are unchanged.
- Undefined: resp_data always equals the captured mux_data, including for address 0.

Decomposition:
- Shared package regread_pkg:
  - REG_IDX_W=5
  - NUM_REGS=32
  - DATA_W default
  - state encoding constants ST_IDLE, ST_ISSUE
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot winner and winner index.
  - Instantiated once; reusable for the write-port arbiter.

Test Plan:
- Reset: hold reset_n=0 with req=4'b1111 → all outputs 0. After release, first grant=4'b0001, and resp_valid at +2 cycles with resp_id=0.
- Single read: req[2]=1, addr2=5'd17, mux model returns 32'hDEAD_0011 → grant=4'b0100 and mux_select=17 at T+1; resp_valid=1, resp_id=2, resp_data=32'hDEAD_0011 at T+2.
- Fairness: req=4'b1111 held for 8 cycles → grant sequence 0,1,2,3,0,1,2,3, one per cycle, back-to-back responses in the same order.
- Wrap and pointer: rr_ptr=3 with req=4'b1001 → grant req3 then req0. Then req=4'b0000 for 2 cycles → rr_ptr stays 1.
- Stall: stall=1 for 3 cycles with req[1]=1 → no grant and rr_ptr unchanged. A read granted the cycle before the stall still returns resp_valid. Grant to req1 arrives 1 cycle after stall drops.
- REGREAD_ZERO_EN, addr=0 and mux_data=32'hFFFF_FFFF:
  - Macro defined → resp_data=0.
  - Macro undefined → resp_data=32'hFFFF_FFFF.
